// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first: one subtractor cell plus a borrow flop.
// Start/busy/done handshake; diff/borr update only on completion.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borr
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bflop_q, bflop_d;
  logic             borr_q, borr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             bit_d;
  logic             bit_bo;
  logic [WIDTH-1:0] res_shift;

  assign bit_d  = a_q[0] ^ b_q[0] ^ bflop_q;
  assign bit_bo = (~a_q[0] & b_q[0])
                | (~(a_q[0] ^ b_q[0]) & bflop_q);

  // The new bit enters at the top so the LSB lands at bit 0 after WIDTH shifts.
  if (WIDTH == 1) begin : g_res1
    assign res_shift = bit_d;
  end else begin : g_resn
    assign res_shift = {bit_d, res_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    bflop_d = bflop_q;
    borr_d  = borr_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          bflop_d = 1'b0;
          cnt_d   = '0;
          res_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        res_d   = res_shift;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        bflop_d = bit_bo;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          diff_d  = res_shift;
          borr_d  = bit_bo;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      bflop_q <= 1'b0;
      borr_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      bflop_q <= bflop_d;
      borr_q  <= borr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign borr = borr_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: timing/arith model for the 8-bit build,
// directed literals, random traffic, exhaustive 4-bit and 1-bit builds.
module tb_serial_subtractor;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, borr;
  logic [W-1:0] diff;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic       busy4, done4, borr4;
  logic [3:0] diff4;

  logic start1 = 1'b0;
  logic a1 = 1'b0;
  logic b1 = 1'b0;
  logic busy1, done1, borr1;
  logic diff1;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borr(borr)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borr(borr4)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .borr(borr1)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: an op accepted at edge e0 is busy after edges e0..e0+W-1,
  // done after edge e0+W, and the next op can be accepted at e0+W+2.
  int           cyc = 0;
  int           e0 = -1;
  int           next_free = 0;
  logic [W-1:0] pend_d = '0;
  logic [W-1:0] cur_d = '0;
  logic         pend_b = 1'b0;
  logic         cur_b = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e0 = -1;
      next_free = 0;
      cur_d = '0;
      cur_b = 1'b0;
    end else begin
      cyc++;
      if (e0 >= 0 && cyc == e0 + W) begin
        cur_d = pend_d;
        cur_b = pend_b;
      end
      if (start && cyc >= next_free) begin
        e0 = cyc;
        pend_d = a - b;
        pend_b = (a < b);
        next_free = cyc + W + 2;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", busy,
          (e0 >= 0 && cyc >= e0 && cyc < e0 + W) ? 1 : 0);
      chk("done", done, (e0 >= 0 && cyc == e0 + W) ? 1 : 0);
      chk("diff", diff, cur_d);
      chk("borr", borr, cur_b);
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((busy || done) && n < 3 * W) begin
      @(negedge clk);
      n++;
    end
    if (busy || done) chk("idle_timeout", 1, 0);
  endtask

  task automatic run8(input logic [W-1:0] ia, input logic [W-1:0] ib,
                      input logic [W-1:0] ed, input logic eb,
                      input string nm);
    int n = 0;
    wait_idle();
    start = 1'b1;
    a = ia;
    b = ib;
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    while (!done && n < W + 3) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_lat"}, n, W);
    chk({nm, "_diff"}, diff, ed);
    chk({nm, "_borr"}, borr, eb);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_borr", borr, 0);
    rst = 1'b0;

    run8(8'h05, 8'h03, 8'h02, 1'b0, "basic");

    // Abort mid-shift: no done pulse, outputs cleared.
    wait_idle();
    start = 1'b1;
    a = 8'hF0;
    b = 8'h0F;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_diff", diff, 0);
    chk("abort_borr", borr, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    run8(8'h10, 8'h01, 8'h0F, 1'b0, "after_abort");

    run8(8'h03, 8'h05, 8'hFE, 1'b1, "borrow");

    // Asynchronous reset between edges clears outputs immediately.
    wait_idle();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_busy", busy, 0);
    chk("async_done", done, 0);
    chk("async_diff", diff, 0);
    chk("async_borr", borr, 0);
    @(negedge clk);
    rst = 1'b0;

    run8(8'h00, 8'h01, 8'hFF, 1'b1, "ripple");
    run8(8'hA5, 8'hA5, 8'h00, 1'b0, "equal");

    // start held high with changing operands: one op per W+2 cycles.
    begin
      int nd = 0;
      wait_idle();
      start = 1'b1;
      for (int j = 1; j <= 45; j++) begin
        a = 8'($urandom);
        b = 8'($urandom);
        @(negedge clk);
        if (done) nd++;
      end
      start = 1'b0;
      chk("held_done_count", nd, 4);
    end

    // Random start pulses, many landing while busy.
    for (int j = 0; j < 400; j++) begin
      start = ($urandom_range(0, 2) == 0);
      a = 8'($urandom);
      b = 8'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);

    // Exhaustive 4-bit build, back to back.
    for (int i = 0; i < 256; i++) begin
      int n = 0;
      int ia = i / 16;
      int ib = i % 16;
      a4 = 4'(ia);
      b4 = 4'(ib);
      start4 = 1'b1;
      while (!busy4 && n < 8) begin
        @(negedge clk);
        n++;
      end
      start4 = 1'b0;
      n = 0;
      while (!done4 && n < 8) begin
        @(negedge clk);
        n++;
      end
      chk("w4_diff", diff4, (ia - ib) & 15);
      chk("w4_borr", borr4, (ia < ib) ? 1 : 0);
    end

    // 1-bit build: half-subtractor truth table.
    for (int i = 0; i < 4; i++) begin
      int n = 0;
      int ia = i / 2;
      int ib = i % 2;
      @(negedge clk);
      a1 = 1'(ia);
      b1 = 1'(ib);
      start1 = 1'b1;
      while (!done1 && n < 6) begin
        @(negedge clk);
        start1 = 1'b0;
        n++;
      end
      start1 = 1'b0;
      chk("w1_diff", diff1, (ia - ib) & 1);
      chk("w1_borr", borr1, (ia < ib) ? 1 : 0);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing diff = a - b, LSB first, one bit per clock.
- The datapath is a single subtractor cell with a registered borrow feedback: half-subtractor logic extended with borrow-in.
- Sits downstream of the combinational half-subtractor cell and reuses its diff/borrow equations sequentially.
- Start/busy/done handshake, for use where area matters more than latency.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepted start edge.
- b  input  WIDTH  subtrahend; captured on the accepted start edge.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse; diff/borr are valid from this cycle onward.
- diff  output  WIDTH  result register, (a - b) mod 2^WIDTH.
- borr  output  1  final borrow out; 1 iff a < b unsigned.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; busy=0, done=0, diff=0, borr=0; internal shift registers, borrow flop and bit counter = 0. Reset mid-operation aborts the operation; no done pulse is produced.
- States:
  - IDLE: busy=0, done=0. On an edge with start=1: A<=a, B<=b, bflop<=0, cnt<=0, result shift reg<=0, go to SHIFT.
  - SHIFT: busy=1. Each edge:
    - d = A[0]^B[0]^bflop
    - bo = (~A[0]&B[0]) | (~(A[0]^B[0])&bflop)
    - result <= {d, result[WIDTH-1:1]}
    - A, B shift right by 1
    - bflop<=bo, cnt<=cnt+1
    - When cnt==WIDTH-1 on this edge: diff<={d, result[WIDTH-1:1]}, borr<=bo, go to DONE.
  - DONE: busy=0, done=1 for exactly one cycle; next edge goes to IDLE unconditionally.
- Latency: start accepted at edge E0; diff/borr updated and done asserted after edge E0+WIDTH; done deasserts at E0+WIDTH+1. Earliest next accepted start is edge E0+WIDTH+2 (throughput WIDTH+2 cycles per op).
- start is ignored in SHIFT and DONE: no queuing, no restart.
- a/b may change after the accepting edge without effect.
- diff/borr hold their last values until the next completion. They do not change during SHIFT, and do not change after reset until the first completion.
- WIDTH=1: a single SHIFT cycle; diff=a^b, borr=~a&b.
- cnt width is $clog2(WIDTH) with a minimum of 1 bit; no wrap occurs within an operation.

Test Plan:
- Reset: assert rst asynchronously between edges -> busy=0, done=0, diff=8'h00, borr=0 immediately, without waiting for a clock edge.
- Basic op: a=8'h05, b=8'h03, start 1 cycle -> busy high 8 cycles, done pulse after edge 8, diff=8'h02, borr=0.
- Borrow cases:
  - a=8'h03, b=8'h05 -> diff=8'hFE, borr=1.
  - a=8'h00, b=8'h01 -> diff=8'hFF, borr=1 (full borrow ripple).
  - a=b=8'hA5 -> diff=8'h00, borr=0.
- Handshake: hold start=1 continuously with changing a/b -> only the IDLE-sampled operands are used; ops complete every 10 cycles; done is never longer than 1 cycle; start pulses during busy are ignored.
- Abort: start a=8'hF0, b=8'h0F, assert rst at SHIFT cycle 4 -> no done pulse, outputs 0. Then release rst and run a=8'h10, b=8'h01 -> diff=8'h0F, borr=0.
- Exhaustive: WIDTH=4 build, all 256 a/b pairs back-to-back -> diff==(a-b)&4'hF and borr==(a<b) on every done pulse; WIDTH=1 build covers the four half-subtractor truth-table rows.
